// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the peripheral side (CPU store path, RX echo path,
// UART transmitter) and the uart_tx_arbiter block.
// master: the surrounding logic that pushes bytes and models the transmitter.
// slave : the arbiter itself.
interface uart_tx_arbiter_if;
  logic       cpu_req;
  logic [7:0] cpu_data;
  logic       cpu_full;
  logic       echo_req;
  logic [7:0] echo_data;
  logic       echo_full;
  logic       tx_status;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       busy;
  logic       grant_id;
  logic       cpu_ovf;
  logic       echo_ovf;
  logic       timeout;
  logic       flag_clr;

  modport slave (
    input  cpu_req, cpu_data, echo_req, echo_data, tx_status, flag_clr,
    output cpu_full, echo_full, tx_data, tx_send, busy, grant_id,
           cpu_ovf, echo_ovf, timeout
  );

  modport master (
    output cpu_req, cpu_data, echo_req, echo_data, tx_status, flag_clr,
    input  cpu_full, echo_full, tx_data, tx_send, busy, grant_id,
           cpu_ovf, echo_ovf, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between a CPU byte FIFO and an
// RX-echo byte FIFO. A round-robin arbiter picks the next byte and a
// four-state sequencer issues a one-cycle send pulse, then follows the
// transmitter's status handshake (with an acknowledge timeout).
// Optional macro UART_ARB_PRIO_EN: when defined, the CPU FIFO has fixed
// priority over the echo FIFO instead of round-robin.
module uart_tx_arbiter #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int TW     = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // FIFO storage (data only, never reset) and control state
  logic [DATA_W-1:0] r_cpu_mem  [DEPTH];
  logic [DATA_W-1:0] r_echo_mem [DEPTH];
  logic [PW-1:0]     r_cpu_wp, r_cpu_rp, r_echo_wp, r_echo_rp;
  logic [CW-1:0]     r_cpu_cnt, r_echo_cnt;
  logic              r_cpu_full, r_echo_full;
  logic              r_cpu_ovf, r_echo_ovf, r_timeout;

  // Sequencer state
  state_t            r_state;
  logic [TW-1:0]     r_wcnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_grant_id;
`ifndef UART_ARB_PRIO_EN
  logic              r_rr_next;   // source preferred when both FIFOs hold data
`endif

  // Combinational control
  state_t            w_next;
  logic              w_cpu_ne, w_echo_ne;
  logic              w_cpu_full_now, w_echo_full_now;
  logic              w_cpu_push, w_echo_push;
  logic              w_cpu_pop, w_echo_pop;
  logic              w_grant, w_sel, w_cnt_inc, w_to_set;
  logic [CW-1:0]     w_cpu_cnt_nxt, w_echo_cnt_nxt;
  logic [DATA_W-1:0] w_head;

  assign w_cpu_ne        = (r_cpu_cnt != '0);
  assign w_echo_ne       = (r_echo_cnt != '0);
  // Fullness comes from the registered count, so a same-cycle pop never
  // makes room for a push.
  assign w_cpu_full_now  = (r_cpu_cnt == CW'(DEPTH));
  assign w_echo_full_now = (r_echo_cnt == CW'(DEPTH));
  assign w_cpu_push      = bus.cpu_req  && !w_cpu_full_now;
  assign w_echo_push     = bus.echo_req && !w_echo_full_now;
  assign w_cpu_pop       = w_grant && !w_sel;
  assign w_echo_pop      = w_grant &&  w_sel;
  assign w_cpu_cnt_nxt   = r_cpu_cnt  + CW'(w_cpu_push)  - CW'(w_cpu_pop);
  assign w_echo_cnt_nxt  = r_echo_cnt + CW'(w_echo_push) - CW'(w_echo_pop);
  assign w_head          = w_sel ? r_echo_mem[r_echo_rp] : r_cpu_mem[r_cpu_rp];

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_send   = (r_state == S_SEND);
  assign bus.busy      = (r_state != S_IDLE) || w_cpu_ne || w_echo_ne;
  assign bus.grant_id  = r_grant_id;
  assign bus.cpu_full  = r_cpu_full;
  assign bus.echo_full = r_echo_full;
  assign bus.cpu_ovf   = r_cpu_ovf;
  assign bus.echo_ovf  = r_echo_ovf;
  assign bus.timeout   = r_timeout;

  // Write accepted bytes into the FIFO storage arrays
  always_ff @(posedge clk) begin
    if (w_cpu_push)  r_cpu_mem[r_cpu_wp]   <= bus.cpu_data;
    if (w_echo_push) r_echo_mem[r_echo_wp] <= bus.echo_data;
  end

  // FIFO pointers, counts, registered full flags and sticky overflow flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_wp    <= '0;
      r_cpu_rp    <= '0;
      r_cpu_cnt   <= '0;
      r_echo_wp   <= '0;
      r_echo_rp   <= '0;
      r_echo_cnt  <= '0;
      r_cpu_full  <= 1'b0;
      r_echo_full <= 1'b0;
      r_cpu_ovf   <= 1'b0;
      r_echo_ovf  <= 1'b0;
    end else begin
      if (w_cpu_push)  r_cpu_wp  <= r_cpu_wp  + PW'(1);
      if (w_cpu_pop)   r_cpu_rp  <= r_cpu_rp  + PW'(1);
      if (w_echo_push) r_echo_wp <= r_echo_wp + PW'(1);
      if (w_echo_pop)  r_echo_rp <= r_echo_rp + PW'(1);
      r_cpu_cnt   <= w_cpu_cnt_nxt;
      r_echo_cnt  <= w_echo_cnt_nxt;
      r_cpu_full  <= (w_cpu_cnt_nxt  == CW'(DEPTH));
      r_echo_full <= (w_echo_cnt_nxt == CW'(DEPTH));
      // A drop in the same cycle as flag_clr keeps the flag set
      if (bus.cpu_req && w_cpu_full_now)        r_cpu_ovf  <= 1'b1;
      else if (bus.flag_clr)                    r_cpu_ovf  <= 1'b0;
      if (bus.echo_req && w_echo_full_now)      r_echo_ovf <= 1'b1;
      else if (bus.flag_clr)                    r_echo_ovf <= 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Sequencer next-state, arbitration and handshake decisions
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_sel     = 1'b0;
    w_cnt_inc = 1'b0;
    w_to_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tx_status && (w_cpu_ne || w_echo_ne)) begin
          w_grant = 1'b1;
`ifdef UART_ARB_PRIO_EN
          w_sel   = !w_cpu_ne;
`else
          if (w_cpu_ne && w_echo_ne) w_sel = r_rr_next;
          else                       w_sel = !w_cpu_ne;
`endif
          w_next  = S_SEND;
        end
      end
      S_SEND:      w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!bus.tx_status) begin
          w_next = S_WAIT_DONE;
        end else if (r_wcnt == TW'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: count the byte as sent, no retry
          w_to_set = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WAIT_DONE: if (bus.tx_status) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Acknowledge wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_SEND) r_wcnt <= '0;
      else if (w_cnt_inc)    r_wcnt <= r_wcnt + TW'(1);
      if (w_to_set)          r_timeout <= 1'b1;
      else if (bus.flag_clr) r_timeout <= 1'b0;
    end
  end

  // Latch the granted byte and its source; they hold until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_data  <= '0;
      r_grant_id <= 1'b0;
    end else if (w_grant) begin
      r_tx_data  <= w_head;
      r_grant_id <= w_sel;
    end
  end

`ifndef UART_ARB_PRIO_EN
  // Round-robin pointer: after a grant, prefer the other source next time
  always_ff @(posedge clk) begin
    if (reset)        r_rr_next <= 1'b0;
    else if (w_grant) r_rr_next <= !w_sel;
  end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter of the peripheral block between two byte sources: the CPU store path (memory-mapped UART TX data writes) and a hardware echo path fed from UART RX. Each source has its own small FIFO; a round-robin arbiter picks the next byte, and a sequencer drives the transmitter's data/send-pulse interface, honouring its status handshake. Sits between the peripheral register decode and the UART transmitter instance.

## Interface
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `ACK_TIMEOUT`, 16: cycles to wait for `tx_status` to fall after a send pulse; ≥2.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset. One clock, `clk`; all state changes on its rising edge.
- `cpu_req` in 1: push `cpu_data` into the CPU FIFO this cycle.
- `cpu_data` in 8: CPU byte.
- `cpu_full` out 1: CPU FIFO holds `DEPTH` entries.
- `echo_req` in 1: push `echo_data` into the echo FIFO.
- `echo_data` in 8: echo byte.
- `echo_full` out 1: echo FIFO full.
- `tx_status` in 1: high = transmitter idle, able to accept a byte.
- `tx_data` out 8: byte presented to the transmitter.
- `tx_send` out 1: one-cycle start pulse to the transmitter.
- `busy` out 1: sequencer not in IDLE, or either FIFO non-empty.
- `grant_id` out 1: source of the current/last byte (0 = CPU, 1 = echo).
- `cpu_ovf` out 1: sticky; a CPU push was dropped.
- `echo_ovf` out 1: sticky; an echo push was dropped.
- `timeout` out 1: sticky; `ACK_TIMEOUT` expired.
- `flag_clr` in 1: clears `cpu_ovf`, `echo_ovf`, `timeout`.

## Operation
- Reset: both FIFOs emptied, sequencer → IDLE, round-robin pointer → CPU. Outputs: `tx_data`=8'h00, `tx_send`=0, `busy`=0, `grant_id`=0, `cpu_full`=`echo_full`=0, all sticky flags 0. Reset overrides all other inputs, including mid-transfer.
- FIFO push: accepted when `req`=1 and count < `DEPTH`. A push while full is dropped and sets the source's `ovf`. Fullness uses the registered count, so a same-cycle pop does not admit a push when full.
- Pointer and count widths: `$clog2(DEPTH)`+1 count bits; read/write pointers wrap modulo `DEPTH`.
- Sequencer states:
  - IDLE: when `tx_status`=1 and any FIFO is non-empty, pop the winner's head into `tx_data`, set `grant_id`, → SEND.
  - SEND: `tx_send`=1 for exactly this cycle; clear the wait counter; → WAIT_ACK.
  - WAIT_ACK: `tx_status`=0 → WAIT_DONE. Otherwise increment the counter; when counter = `ACK_TIMEOUT`-1, set `timeout` and → IDLE. The byte is considered sent; there is no retry.
  - WAIT_DONE: `tx_status`=1 → IDLE.
- Arbitration: if both FIFOs are non-empty, grant the source not granted last; if only one is non-empty, grant it. The pointer updates only on a grant.
- `tx_data` holds its value until the next grant.
- `flag_clr` and a flag-setting event in the same cycle: the set wins.

## Timing
- Push sampled at edge N → count visible in cycle N+1 → IDLE grants at edge N+1 → `tx_send` high during cycle N+2. `tx_data` is valid in that same cycle and stays stable afterwards.
- Minimum spacing between `tx_send` pulses is 4 cycles (SEND, WAIT_ACK, WAIT_DONE, IDLE).
- `cpu_full`/`echo_full` are registered and change one cycle after the push or pop that causes the change.
- `busy` is combinational from state and counts.

## Configuration
- `UART_ARB_PRIO_EN`:
  - Defined: fixed priority. The CPU FIFO always wins when non-empty; the round-robin pointer is unused. `grant_id` behaves the same way.
  - Undefined: round-robin as described above.

## Test plan
- Reset, then CPU push 8'h41 with `tx_status`=1, and the bench model lowers `tx_status` one cycle after `tx_send` and holds it low for 10 cycles. Required: `tx_send` high exactly two cycles after the push, `tx_data`=8'h41, `grant_id`=0, `busy` low after `tx_status` returns high.
- Fill the CPU FIFO with 0x01–0x04 and the echo FIFO with 0x11–0x14. Required: send order 01, 11, 02, 12, 03, 13, 04, 14 without the macro; 01–04 then 11–14 with `UART_ARB_PRIO_EN` defined.
- Five back-to-back CPU pushes with `tx_status` held 0. Required: `cpu_full`=1 after the fourth push, the fifth is dropped, `cpu_ovf`=1; `flag_clr` returns it to 0.
- `tx_status` stuck at 1 after `tx_send`. Required: `timeout`=1 exactly `ACK_TIMEOUT` cycles into WAIT_ACK, return to IDLE, and the next queued byte is sent.
- Assert `reset` during WAIT_DONE with both FIFOs holding 2 entries. Required: next cycle all outputs at reset values, FIFOs empty, and no `tx_send` after reset deasserts.
